// File: rtl/cnn_pkg.sv
// Shared defaults and the frame-buffer state encoding for the CNN two-layer datapath.
package cnn_pkg;

    localparam int DEF_DATANUM = 15;
    localparam int DEF_DW      = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_write_ptr.sv
// One-hot rotating slot selector. Home position is the MSB; each enable rotates one place left.
module onehot_write_ptr
    import cnn_pkg::*;
#(
    parameter int DATANUM = DEF_DATANUM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    output logic [DATANUM-1:0] ptr
);

    localparam logic [DATANUM-1:0] HOME = {1'b1, {(DATANUM-1){1'b0}}};

    logic [DATANUM-1:0] ptr_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr_reg <= HOME;
        end else if (en) begin
            ptr_reg <= {ptr_reg[DATANUM-2:0], ptr_reg[DATANUM-1]};
        end
    end

    assign ptr = ptr_reg;

    // A corrupted pointer would silently write zero or several slots at once.
    ptr_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot(ptr_reg));

endmodule

// File: rtl/write_reg_bank.sv
// Collects DATANUM samples into a slot bank and offers the whole frame downstream with valid/ready.
module write_reg_bank
    import cnn_pkg::*;
#(
    parameter int DATANUM = DEF_DATANUM,
    parameter int DW      = DEF_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATANUM*DW-1:0]        out_data,
    output logic [DATANUM-1:0]           wr_ptr,
    output logic [$clog2(DATANUM+1)-1:0] fill_cnt,
    output logic                         frame_done
);

    localparam int CW = $clog2(DATANUM+1);

    state_t        state_reg, state_next;
    logic [CW-1:0] fill_cnt_reg, fill_cnt_next;
    logic          frame_done_reg, frame_done_next;
    logic          accept;
    logic          release_frame;

    assign in_ready      = (state_reg == FILL) && !clear;
    assign accept        = in_valid && in_ready;
    assign release_frame = (state_reg == HOLD) && out_ready && !clear;

    onehot_write_ptr #(
        .DATANUM(DATANUM)
    ) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (accept),
        .ptr   (wr_ptr)
    );

    always_comb begin
        state_next      = state_reg;
        fill_cnt_next   = fill_cnt_reg;
        frame_done_next = 1'b0;
        if (clear) begin
            state_next    = FILL;
            fill_cnt_next = '0;
        end else if (accept) begin
            fill_cnt_next = fill_cnt_reg + CW'(1);
            if (fill_cnt_reg == CW'(DATANUM-1)) begin
                state_next = HOLD;
            end
        end else if (release_frame) begin
            state_next      = FILL;
            fill_cnt_next   = '0;
            frame_done_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            fill_cnt_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fill_cnt_reg   <= fill_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Each slot is enabled directly by its pointer bit, so no address decode is needed.
    genvar gi;
    generate
        for (gi = 0; gi < DATANUM; gi++) begin : g_slot
            logic [DW-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (accept && wr_ptr[gi]) begin
                    slot_reg <= in_data;
                end
            end

            assign out_data[gi*DW +: DW] = slot_reg;
        end
    endgenerate

    assign out_valid  = (state_reg == HOLD);
    assign fill_cnt   = fill_cnt_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_write_reg_bank.sv
// Randomised and directed bench for write_reg_bank against a frame-level reference model.
module tb_write_reg_bank;

    localparam int N  = 15;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, clear, in_valid, in_ready, out_valid, out_ready, frame_done;
    logic [W-1:0]    in_data;
    logic [N*W-1:0]  out_data;
    logic [N-1:0]    wr_ptr;
    logic [CW-1:0]   fill_cnt;

    logic            rst4, clear4, in_valid4, in_ready4, out_valid4, out_ready4, frame_done4;
    logic [W-1:0]    in_data4;
    logic [4*W-1:0]  out_data4;
    logic [3:0]      wr_ptr4;
    logic [2:0]      fill_cnt4;

    write_reg_bank #(.DATANUM(N), .DW(W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .wr_ptr(wr_ptr), .fill_cnt(fill_cnt), .frame_done(frame_done)
    );

    write_reg_bank #(.DATANUM(4), .DW(W)) dut4 (
        .clk(clk), .rst(rst4), .clear(clear4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .wr_ptr(wr_ptr4), .fill_cnt(fill_cnt4), .frame_done(frame_done4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view (held flag, sample count, slot contents).
    bit       m_hold;
    bit       m_done;
    int       m_cnt;
    logic [W-1:0] m_slots [N];

    function automatic logic [N-1:0] m_ptr();
        logic [N-1:0] one;
        one = 1;
        return one << ((m_cnt + N - 1) % N);
    endfunction

    function automatic logic [N*W-1:0] m_frame();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = m_slots[k];
        return f;
    endfunction

    task automatic tick();
        if (rst) begin
            m_hold = 0; m_cnt = 0; m_done = 0;
            for (int k = 0; k < N; k++) m_slots[k] = '0;
        end else if (clear) begin
            m_hold = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_hold && in_valid) begin
                m_slots[(m_cnt + N - 1) % N] = in_data;
                m_cnt++;
                if (m_cnt == N) m_hold = 1;
            end else if (m_hold && out_ready) begin
                m_hold = 0; m_cnt = 0; m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clear = 0; in_valid = 0; out_ready = 0; in_data = '0;
        tick(); tick();
        rst = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL reset_fill_cnt got %0d want 0", fill_cnt); end
        checks++; if (wr_ptr !== 15'h4000) begin errors++; $display("FAIL reset_wr_ptr got %h want 4000", wr_ptr); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        $display("reset: out_valid=%b fill_cnt=%0d wr_ptr=%h", out_valid, fill_cnt, wr_ptr);
    endtask

    task automatic test_fill();
        logic [W-1:0] exp;
        for (int i = 1; i <= N; i++) begin
            in_valid = 1; in_data = W'(i);
            tick();
            checks++; if (fill_cnt !== CW'(i)) begin errors++; $display("FAIL fill_cnt[%0d] got %0d want %0d", i, fill_cnt, i); end
            checks++; if (wr_ptr !== m_ptr()) begin errors++; $display("FAIL fill_ptr[%0d] got %h want %h", i, wr_ptr, m_ptr()); end
            $display("fill: sample %h fill_cnt=%0d wr_ptr=%h", in_data, fill_cnt, wr_ptr);
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        for (int k = 0; k < N; k++) begin
            exp = W'(((k + 1) % N) + 1);
            checks++; if (out_data[k*W +: W] !== exp) begin errors++; $display("FAIL fill_slot%0d got %h want %h", k, out_data[k*W +: W], exp); end
        end
    endtask

    task automatic test_hold_release();
        logic [N*W-1:0] snap;
        snap = m_frame();
        out_ready = 0; in_valid = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_data !== snap) begin errors++; $display("FAIL hold_data got %h want %h", out_data, snap); end
            checks++; if (fill_cnt !== 4'd15) begin errors++; $display("FAIL hold_fill_cnt got %0d want 15", fill_cnt); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid got %b want 1", out_valid); end
            $display("hold: cycle %0d out_valid=%b fill_cnt=%0d", c, out_valid, fill_cnt);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL release_frame_done got %b want 1", frame_done); end
        checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL release_fill_cnt got %0d want 0", fill_cnt); end
        checks++; if (wr_ptr !== 15'h4000) begin errors++; $display("FAIL release_wr_ptr got %h want 4000", wr_ptr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL release_pulse_len got %b want 0", frame_done); end
        $display("release: frame_done pulse seen, wr_ptr=%h", wr_ptr);
    endtask

    task automatic test_backpressure();
        int frames = 0;
        for (int c = 0; c < 2000 && frames < 3; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++; if (out_valid !== m_hold) begin errors++; $display("FAIL bp_out_valid c%0d got %b want %b", c, out_valid, m_hold); end
            checks++; if (fill_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL bp_fill_cnt c%0d got %0d want %0d", c, fill_cnt, m_cnt); end
            checks++; if (wr_ptr !== m_ptr()) begin errors++; $display("FAIL bp_wr_ptr c%0d got %h want %h", c, wr_ptr, m_ptr()); end
            checks++; if (frame_done !== m_done) begin errors++; $display("FAIL bp_frame_done c%0d got %b want %b", c, frame_done, m_done); end
            checks++; if (in_ready !== !m_hold) begin errors++; $display("FAIL bp_in_ready c%0d got %b want %b", c, in_ready, !m_hold); end
            if (m_hold) begin
                checks++; if (out_data !== m_frame()) begin errors++; $display("FAIL bp_out_data c%0d got %h want %h", c, out_data, m_frame()); end
            end
            if (m_done) begin
                frames++;
                checks++; if (wr_ptr !== 15'h4000) begin errors++; $display("FAIL bp_frame_ptr got %h want 4000", wr_ptr); end
            end
            $display("bp: c%0d iv=%b or=%b d=%h fill_cnt=%0d out_valid=%b done=%b", c, in_valid, out_ready, in_data, fill_cnt, out_valid, frame_done);
        end
        in_valid = 0; out_ready = 0;
        checks++; if (frames < 3) begin errors++; $display("FAIL bp_timeout frames got %0d want 3", frames); end
    endtask

    task automatic test_clear_mid();
        logic [W-1:0] exp;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1; in_data = W'($urandom); tick();
        end
        in_valid = 0; clear = 1;
        tick();
        clear = 0;
        checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL clr_fill_cnt got %0d want 0", fill_cnt); end
        checks++; if (wr_ptr !== 15'h4000) begin errors++; $display("FAIL clr_wr_ptr got %h want 4000", wr_ptr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid got %b want 0", out_valid); end
        for (int i = 0; i < N; i++) begin
            in_valid = 1; in_data = W'(8'hA0 + i); tick();
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_refill_valid got %b want 1", out_valid); end
        for (int i = 0; i < N; i++) begin
            exp = W'(8'hA0 + i);
            checks++; if (out_data[((i + N - 1) % N)*W +: W] !== exp) begin
                errors++; $display("FAIL clr_slot%0d got %h want %h", (i + N - 1) % N, out_data[((i + N - 1) % N)*W +: W], exp);
            end
        end
        $display("clear_mid: refilled frame %h", out_data);
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_clear_collision();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = W'(i + 1); tick();
        end
        clear = 1; in_valid = 1; in_data = 8'h5A;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL coll_in_ready got %b want 0", in_ready); end
        tick();
        clear = 0; in_valid = 0;
        checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL coll_fill_cnt got %0d want 0", fill_cnt); end
        checks++; if (wr_ptr !== 15'h4000) begin errors++; $display("FAIL coll_wr_ptr got %h want 4000", wr_ptr); end
        for (int i = 0; i < N; i++) begin
            in_valid = 1; in_data = W'($urandom); tick();
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL coll_full got %b want 1", out_valid); end
        clear = 1; tick(); clear = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_clear_valid got %b want 0", out_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL hold_clear_done got %b want 0", frame_done); end
        checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL hold_clear_cnt got %0d want 0", fill_cnt); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL hold_clear_done2 got %b want 0", frame_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_clear_ready got %b want 1", in_ready); end
        $display("clear_collision: fill_cnt=%0d out_valid=%b", fill_cnt, out_valid);
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < N; i++) begin
            in_valid = 1; in_data = W'($urandom_range(1, 255)); tick();
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rh_full got %b want 1", out_valid); end
        rst = 1; tick(); rst = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_out_valid got %b want 0", out_valid); end
        checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL rh_fill_cnt got %0d want 0", fill_cnt); end
        checks++; if (wr_ptr !== 15'h4000) begin errors++; $display("FAIL rh_wr_ptr got %h want 4000", wr_ptr); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rh_frame_done got %b want 0", frame_done); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rh_out_data got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rh_in_ready got %b want 1", in_ready); end
        $display("reset_hold: out_valid=%b wr_ptr=%h", out_valid, wr_ptr);
    endtask

    task automatic test_datanum4();
        rst4 = 1; tick(); tick(); rst4 = 0;
        checks++; if (wr_ptr4 !== 4'b1000) begin errors++; $display("FAIL d4_reset_ptr got %b want 1000", wr_ptr4); end
        checks++; if (fill_cnt4 !== 3'd0) begin errors++; $display("FAIL d4_reset_cnt got %0d want 0", fill_cnt4); end
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1; in_data4 = W'(8'h11 + i); tick();
            $display("d4: sample %h wr_ptr=%b fill_cnt=%0d", in_data4, wr_ptr4, fill_cnt4);
        end
        in_valid4 = 0;
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL d4_out_valid got %b want 1", out_valid4); end
        checks++; if (fill_cnt4 !== 3'd4) begin errors++; $display("FAIL d4_fill_cnt got %0d want 4", fill_cnt4); end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL d4_in_ready got %b want 0", in_ready4); end
        checks++; if (wr_ptr4 !== 4'b1000) begin errors++; $display("FAIL d4_wr_ptr got %b want 1000", wr_ptr4); end
        checks++; if (out_data4 !== 32'h11141312) begin errors++; $display("FAIL d4_out_data got %h want 11141312", out_data4); end
        out_ready4 = 1; tick(); out_ready4 = 0;
        checks++; if (frame_done4 !== 1'b1) begin errors++; $display("FAIL d4_frame_done got %b want 1", frame_done4); end
    endtask

    initial begin
        rst = 1; clear = 0; in_valid = 0; out_ready = 0; in_data = '0;
        rst4 = 1; clear4 = 0; in_valid4 = 0; out_ready4 = 0; in_data4 = '0;
        m_hold = 0; m_done = 0; m_cnt = 0;
        for (int k = 0; k < N; k++) m_slots[k] = '0;
        test_reset();
        test_fill();
        test_hold_release();
        test_backpressure();
        test_clear_mid();
        test_clear_collision();
        test_reset_hold();
        test_datanum4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
